playlist_sequencer: RTL and testbench
=====================================

// Module: playlist_sequencer
// PURPOSE
//  Sequences the auto-play engine across the song list. Turns next/prev/play
//  button levels into edge events and runs play/pause/stop. Auto-advances to
//  the next song after an inter-song gap. Drives selected_song plus start/run
//  controls into AutoPlay and the song digit into the 7-seg decoder.
// PARAMETERS
//  TOTAL_SONGS   2            number of songs; song indices 0..TOTAL_SONGS-1 (>=1, <=16)
//  GAP_CYCLES    100_000_000  silent clk cycles between songs on auto-advance (>=1)
//  AUTO_ADVANCE  1            1: song_done advances and replays; 0: song_done stops
// PORTS
//  clk           in   1  system clock
//  reset         in   1  asynchronous, active-high reset
//  btn_next      in   1  debounced, synchronous level; rising edge = next song
//  btn_prev      in   1  debounced, synchronous level; rising edge = previous song
//  btn_play      in   1  debounced, synchronous level; rising edge = play/pause toggle
//  song_done     in   1  1-cycle pulse from player at end of current song
//  song_number   out  4  selected song index, to player and 7-seg decoder
//  player_start  out  1  1-cycle pulse: player restarts current song from note 0
//  player_run    out  1  player may advance/sound; low = paused or silent
//  state         out  2  00 IDLE, 01 PLAY, 10 PAUSE, 11 GAP
// BEHAVIOUR
//  Reset (async): state=IDLE, song_number=0, player_start=0, player_run=0, gap counter=0.
//   Edge-detect history registers reset to 1, so a button held through reset
//   produces no event.
//  Edges: ev_x = btn_x & ~btn_x_q. Event acts on the same clock edge at which
//   btn_x_q updates, so outputs change 1 cycle after the level rises.
//  Priority within one cycle:
//   - play edge first; any nav edge and song_done in that cycle are dropped.
//   - next & prev together: both dropped.
//   - any button event beats song_done; song_done is dropped.
//  Nav arithmetic: next: n==TOTAL_SONGS-1 ? 0 : n+1; prev: n==0 ? TOTAL_SONGS-1 : n-1.
//   TOTAL_SONGS=1 leaves the index at 0.
//  Transitions on events:
//   IDLE : play -> PLAY + start.  nav -> update song, stay IDLE (no start).
//   PLAY : play -> PAUSE.  nav -> update song, stay PLAY + start.  song_done -> see below.
//   PAUSE: play -> PLAY, resume (no start).  nav -> update song, -> PLAY + start.
//   GAP  : play -> IDLE, gap cancelled.  nav -> update song, -> PLAY + start (gap aborted).
//  song_done:
//   - honoured only in PLAY; ignored in IDLE, PAUSE and GAP.
//   - AUTO_ADVANCE=1: song = next (wrap), counter = GAP_CYCLES-1, -> GAP.
//   - AUTO_ADVANCE=0: -> IDLE, song unchanged.
//  GAP: counter decrements every cycle. In the cycle it reads 0 -> PLAY + start.
//   PLAY therefore begins exactly GAP_CYCLES cycles after song_done is sampled.
//  Outputs:
//   - player_run = (state==PLAY), registered.
//   - player_start is registered and high for exactly the first cycle of each
//     (re)entry into PLAY marked "+ start"; it always coincides with player_run=1.
//   - song_number changes in the same cycle as player_start when both apply.
//  Counter width: $clog2(GAP_CYCLES+1); no wrap, held at 0 outside GAP.
//  Reset mid-song or mid-gap: immediate return to reset values; no start pulse.
// TESTING (TOTAL_SONGS=3, GAP_CYCLES=4, AUTO_ADVANCE=1 unless noted)
//  1 Hold btn_next high across reset release -> no event, song_number=0, state=IDLE.
//  2 IDLE, pulse next x3 -> song 1,2,0 (wrap), no start; then prev -> song 2, no start.
//  3 IDLE, play edge -> next cycle: state=01, start=1 for 1 cycle, run=1.
//    Play again -> state=10, run=0. Play again -> state=01, run=1, start=0.
//  4 PLAY song 2, song_done -> state=11, song=0, run=0. 4 cycles later:
//    state=01, start=1. Repeat with a next edge at gap cycle 2 -> song=1, PLAY+start at once.
//  5 PLAY, next and prev rise together -> no change. Next + song_done same cycle ->
//    song+1, restart, no GAP entry.
//  6 AUTO_ADVANCE=0, PLAY, song_done -> IDLE, song unchanged. Assert reset during GAP ->
//    all outputs to reset values asynchronously.

Source files
------------

// File: rtl/playlist_sequencer.sv
// Song-list sequencer: turns button levels into edge events, runs play/pause/stop
// and auto-advances to the next song after a fixed inter-song gap.
module playlist_sequencer #(
  parameter int TOTAL_SONGS  = 2,
  parameter int GAP_CYCLES   = 100_000_000,
  parameter int AUTO_ADVANCE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_play,
  input  logic       song_done,
  output logic [3:0] song_number,
  output logic       player_start,
  output logic       player_run,
  output logic [1:0] state
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [3:0]       LAST_SONG = 4'(TOTAL_SONGS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PLAY  = 2'b01,
    S_PAUSE = 2'b10,
    S_GAP   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       song_q, song_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             run_q;
  logic             next_q, prev_q, play_q;
  logic             ev_next, ev_prev, ev_play, ev_nav, ev_any;

  function automatic logic [3:0] wrap_next(input logic [3:0] n);
    return (n == LAST_SONG) ? 4'd0 : n + 4'd1;
  endfunction

  function automatic logic [3:0] wrap_prev(input logic [3:0] n);
    return (n == 4'd0) ? LAST_SONG : n - 4'd1;
  endfunction

  assign ev_next = btn_next & ~next_q;
  assign ev_prev = btn_prev & ~prev_q;
  assign ev_play = btn_play & ~play_q;
  // Simultaneous next+prev cancel each other but still count as a button event.
  assign ev_nav  = (ev_next ^ ev_prev) & ~ev_play;
  assign ev_any  = ev_next | ev_prev | ev_play;

  // History registers reset high so a button held through reset gives no event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      song_q  <= 4'd0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      run_q   <= 1'b0;
      next_q  <= 1'b1;
      prev_q  <= 1'b1;
      play_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      song_q  <= song_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      run_q   <= (state_d == S_PLAY);
      next_q  <= btn_next;
      prev_q  <= btn_prev;
      play_q  <= btn_play;
    end
  end

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    cnt_d   = '0;
    start_d = 1'b0;
    if (ev_play) begin
      case (state_q)
        S_IDLE:  begin state_d = S_PLAY; start_d = 1'b1; end
        S_PLAY:  state_d = S_PAUSE;
        S_PAUSE: state_d = S_PLAY;
        default: state_d = S_IDLE;
      endcase
    end else if (ev_nav) begin
      song_d = ev_next ? wrap_next(song_q) : wrap_prev(song_q);
      if (state_q != S_IDLE) begin
        state_d = S_PLAY;
        start_d = 1'b1;
      end
    end else if (!ev_any && song_done && state_q == S_PLAY) begin
      if (AUTO_ADVANCE != 0) begin
        song_d  = wrap_next(song_q);
        cnt_d   = GAP_LOAD;
        state_d = S_GAP;
      end else begin
        state_d = S_IDLE;
      end
    end else if (state_q == S_GAP) begin
      if (cnt_q == '0) begin
        state_d = S_PLAY;
        start_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state        = state_q;
    song_number  = song_q;
    player_start = start_q;
    player_run   = run_q;
  end

endmodule

// File: tb/tb_playlist_sequencer.sv
// Bench for playlist_sequencer: two DUTs (auto-advance on/off) on shared inputs,
// each checked every cycle against an event-level model plus literal spot checks.
module tb_playlist_sequencer;
  localparam int NS  = 3;
  localparam int GAP = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bn = 1'b1, bp = 1'b0, bpl = 1'b0, sd = 1'b0;
  logic [3:0] song0, song1;
  logic       start0, start1, run0, run1;
  logic [1:0] st0, st1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  playlist_sequencer #(.TOTAL_SONGS(NS), .GAP_CYCLES(GAP), .AUTO_ADVANCE(1)) dut0 (
    .clk(clk), .reset(reset), .btn_next(bn), .btn_prev(bp), .btn_play(bpl),
    .song_done(sd), .song_number(song0), .player_start(start0),
    .player_run(run0), .state(st0));

  playlist_sequencer #(.TOTAL_SONGS(NS), .GAP_CYCLES(GAP), .AUTO_ADVANCE(0)) dut1 (
    .clk(clk), .reset(reset), .btn_next(bn), .btn_prev(bp), .btn_play(bpl),
    .song_done(sd), .song_number(song1), .player_start(start1),
    .player_run(run1), .state(st1));

  // st: 0 idle, 1 play, 2 pause, 3 gap; el = cycles spent since song_done
  typedef struct packed {
    logic [1:0]  st;
    logic [3:0]  song;
    logic [31:0] el;
    logic        start;
    logic        pn;
    logic        pp;
    logic        pl;
  } model_t;

  localparam model_t MRESET = '{st: 2'd0, song: 4'd0, el: 32'd0, start: 1'b0,
                                pn: 1'b1, pp: 1'b1, pl: 1'b1};

  model_t m0 = MRESET;
  model_t m1 = MRESET;

  function automatic model_t step(input model_t s, input logic n, input logic p,
                                  input logic pl, input logic done, input bit auto_adv);
    model_t r = s;
    logic en, ep, epl;
    int song;
    song = int'(s.song);
    en  = n & ~s.pn;
    ep  = p & ~s.pp;
    epl = pl & ~s.pl;
    r.pn = n; r.pp = p; r.pl = pl;
    r.start = 1'b0;
    if (epl) begin
      if (s.st == 2'd0) begin r.st = 2'd1; r.start = 1'b1; end
      else if (s.st == 2'd1) r.st = 2'd2;
      else if (s.st == 2'd2) r.st = 2'd1;
      else r.st = 2'd0;
    end else if (en != ep) begin
      song = en ? (song + 1) % NS : (song + NS - 1) % NS;
      r.song = 4'(song);
      if (s.st != 2'd0) begin r.st = 2'd1; r.start = 1'b1; end
    end else if (!en && done && s.st == 2'd1) begin
      if (auto_adv) begin
        r.song = 4'((song + 1) % NS);
        r.st = 2'd3;
        r.el = 32'd0;
      end else begin
        r.st = 2'd0;
      end
    end else if (s.st == 2'd3) begin
      r.el = s.el + 32'd1;
      if (r.el == 32'(GAP)) begin r.st = 2'd1; r.start = 1'b1; end
    end
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= MRESET;
      m1 <= MRESET;
    end else begin
      m0 <= step(m0, bn, bp, bpl, sd, 1'b1);
      m1 <= step(m1, bn, bp, bpl, sd, 1'b0);
    end
  end

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cmp("d0_state", int'(st0), int'(m0.st));
    cmp("d0_song",  int'(song0), int'(m0.song));
    cmp("d0_start", int'(start0), int'(m0.start));
    cmp("d0_run",   int'(run0), int'(m0.st == 2'd1));
    cmp("d1_state", int'(st1), int'(m1.st));
    cmp("d1_song",  int'(song1), int'(m1.song));
    cmp("d1_start", int'(start1), int'(m1.start));
    cmp("d1_run",   int'(run1), int'(m1.st == 2'd1));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // held next across reset release: no event
    #1 reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    cmp("lit_hold_song", int'(song0), 0);
    cmp("lit_hold_state", int'(st0), 0);
    bn = 1'b0;
    tick(1);

    // IDLE navigation with wrap
    bn = 1'b1; tick(1); bn = 1'b0; tick(1);
    cmp("lit_next1", int'(song0), 1);
    bn = 1'b1; tick(1); bn = 1'b0; tick(1);
    cmp("lit_next2", int'(song0), 2);
    bn = 1'b1; tick(1); bn = 1'b0; tick(1);
    cmp("lit_next_wrap", int'(song0), 0);
    bp = 1'b1; tick(1); bp = 1'b0; tick(1);
    cmp("lit_prev_wrap", int'(song0), 2);
    cmp("lit_idle_nostart", int'(start0), 0);

    // play / pause / resume
    bpl = 1'b1; tick(1);
    cmp("lit_play_state", int'(st0), 1);
    cmp("lit_play_start", int'(start0), 1);
    cmp("lit_play_run", int'(run0), 1);
    bpl = 1'b0; tick(1);
    cmp("lit_start_1cyc", int'(start0), 0);
    bpl = 1'b1; tick(1); bpl = 1'b0;
    cmp("lit_pause_state", int'(st0), 2);
    cmp("lit_pause_run", int'(run0), 0);
    tick(1);
    bpl = 1'b1; tick(1); bpl = 1'b0;
    cmp("lit_resume_state", int'(st0), 1);
    cmp("lit_resume_nostart", int'(start0), 0);
    tick(1);

    // song_done on song 2 -> gap, then PLAY exactly GAP cycles later
    sd = 1'b1; tick(1); sd = 1'b0;
    cmp("lit_gap_state", int'(st0), 3);
    cmp("lit_gap_song", int'(song0), 0);
    cmp("lit_gap_run", int'(run0), 0);
    cmp("lit_noauto_state", int'(st1), 0);
    cmp("lit_noauto_song", int'(song1), 2);
    tick(3);
    cmp("lit_gap_still", int'(st0), 3);
    tick(1);
    cmp("lit_gap_end_state", int'(st0), 1);
    cmp("lit_gap_end_start", int'(start0), 1);
    tick(1);

    // next edge during gap aborts it immediately
    sd = 1'b1; tick(1); sd = 1'b0;
    tick(1);
    bn = 1'b1; tick(1);
    cmp("lit_gap_nav_state", int'(st0), 1);
    cmp("lit_gap_nav_start", int'(start0), 1);
    cmp("lit_gap_nav_song", int'(song0), 2);
    bn = 1'b0; tick(1);

    // play edge during gap cancels to IDLE
    sd = 1'b1; tick(1); sd = 1'b0;
    bpl = 1'b1; tick(1); bpl = 1'b0;
    cmp("lit_gap_cancel", int'(st0), 0);
    tick(6);
    cmp("lit_gap_cancel_hold", int'(st0), 0);

    // next+prev together dropped; next beats song_done
    bpl = 1'b1; tick(1); bpl = 1'b0; tick(1);
    bn = 1'b1; bp = 1'b1; tick(1);
    cmp("lit_both_song", int'(song0), 0);
    cmp("lit_both_nostart", int'(start0), 0);
    bn = 1'b0; bp = 1'b0; tick(1);
    bn = 1'b1; sd = 1'b1; tick(1);
    cmp("lit_nav_done_state", int'(st0), 1);
    cmp("lit_nav_done_start", int'(start0), 1);
    cmp("lit_nav_done_song", int'(song0), 1);
    bn = 1'b0; sd = 1'b0; tick(6);
    cmp("lit_nav_done_nogap", int'(st0), 1);

    // pause ignores song_done; nav from pause restarts
    bpl = 1'b1; tick(1); bpl = 1'b0; tick(1);
    sd = 1'b1; tick(1); sd = 1'b0;
    cmp("lit_pause_done", int'(st0), 2);
    bp = 1'b1; tick(1); bp = 1'b0;
    cmp("lit_pause_nav_state", int'(st0), 1);
    cmp("lit_pause_nav_start", int'(start0), 1);
    cmp("lit_pause_nav_song", int'(song0), 0);
    tick(2);

    // fresh start, then asynchronous reset in the middle of a gap
    reset = 1'b1; tick(1); reset = 1'b0; tick(1);
    bpl = 1'b1; tick(1); bpl = 1'b0; tick(1);
    sd = 1'b1; tick(1); sd = 1'b0;
    cmp("lit_noauto_idle", int'(st1), 0);
    cmp("lit_noauto_keep", int'(song1), 0);
    tick(1);
    #2 reset = 1'b1;
    #1;
    cmp("lit_areset_state", int'(st0), 0);
    cmp("lit_areset_song", int'(song0), 0);
    cmp("lit_areset_run", int'(run0), 0);
    cmp("lit_areset_start", int'(start0), 0);
    tick(2);
    reset = 1'b0;
    tick(GAP + 2);
    cmp("lit_post_reset", int'(st0), 0);
    cmp("lit_post_reset_start", int'(start0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
